// File: rtl/bus_arbiter_rr_if.sv
// Shared system-bus arbitration signals. The master modport is the arbiter's
// view (takes requests, drives grants); the slave modport is the requesters' view.
interface bus_arbiter_rr_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] busreq;
  logic [NUM_REQ-1:0] busurgent;
  logic [NUM_REQ-1:0] busidle;
  logic [NUM_REQ-1:0] busgrant;
  logic [ID_W-1:0]    grant_id;
  logic               bus_owned;
  logic               grant_timeout;

  modport master (
    input  busreq, busurgent, busidle,
    output busgrant, grant_id, bus_owned, grant_timeout
  );

  modport slave (
    output busreq, busurgent, busidle,
    input  busgrant, grant_id, bus_owned, grant_timeout
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter with urgent override and a grant/idle handshake.
// Optional grant watchdog is built when BUS_ARBITER_WATCHDOG_EN is defined.
module bus_arbiter_rr #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = $clog2(NUM_REQ),
  parameter int unsigned GRANT_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_rr_if.master  bus
);

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_GRANTED = 2'd1,
    ST_BUSY    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               owned_q, owned_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] urgent_req;
  logic [NUM_REQ-1:0] cand;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    ptr_next_owner;

`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(GRANT_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Watchdog depth only matters when the watchdog is built.
  logic unused_grant_timeout_cfg;
  assign unused_grant_timeout_cfg = (GRANT_TIMEOUT != 0);
`endif

  // First candidate at or above ptr, wrapping to 0.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_REQ-1:0] c,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] win;
    logic            found;
    int unsigned     idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && c[ID_W'(idx)]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign urgent_req     = bus.busreq & bus.busurgent;
  assign cand           = (|urgent_req) ? urgent_req : bus.busreq;
  assign winner         = pick_rr(cand, ptr_q);
  assign ptr_next_owner = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      owned_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef BUS_ARBITER_WATCHDOG_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      owned_q   <= owned_d;
      timeout_q <= timeout_d;
`ifdef BUS_ARBITER_WATCHDOG_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    id_d      = id_q;
    owned_d   = owned_q;
    timeout_d = 1'b0;
`ifdef BUS_ARBITER_WATCHDOG_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_ARB: begin
        if (|bus.busreq) begin
          state_d = ST_GRANTED;
          grant_d = NUM_REQ'(1) << winner;
          id_d    = winner;
          owned_d = 1'b1;
`ifdef BUS_ARBITER_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANTED: begin
        if (!bus.busidle[id_q]) begin
          state_d = ST_BUSY;
        end else if (!bus.busreq[id_q]) begin
          // Withdrawn before starting: owner keeps its turn.
          state_d = ST_ARB;
          grant_d = '0;
          owned_d = 1'b0;
`ifdef BUS_ARBITER_WATCHDOG_EN
        end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
          state_d   = ST_ARB;
          grant_d   = '0;
          owned_d   = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = ptr_next_owner;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_BUSY: begin
        if (bus.busidle[id_q]) begin
          state_d = ST_ARB;
          grant_d = '0;
          owned_d = 1'b0;
          ptr_d   = ptr_next_owner;
        end
      end
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
        owned_d = 1'b0;
      end
    endcase
  end

  assign bus.busgrant  = grant_q;
  assign bus.grant_id  = id_q;
  assign bus.bus_owned = owned_q;
`ifdef BUS_ARBITER_WATCHDOG_EN
  assign bus.grant_timeout = timeout_q;
`else
  assign bus.grant_timeout = 1'b0;
  logic unused_timeout_q;
  assign unused_timeout_q = timeout_q;
`endif

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor to the two-requester icache/dcache bus arbiter.
- Arbitrates one shared system bus among NUM_REQ requesters: icache, dcache, and future page-table walker or DMA ports.
- Round-robin fairness, plus an urgent-request override.
- Uses a grant/idle ownership handshake so a bus transaction is never cut mid-burst.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), width of the encoded grant index
GRANT_TIMEOUT, 16, cycles a granted requester may hold the grant without starting a transaction (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
busreq  input  NUM_REQ  per-requester bus request, level
busurgent  input  NUM_REQ  per-requester urgent qualifier; ignored unless the matching busreq is set
busidle  input  NUM_REQ  per-requester idle flag; low while that requester drives a bus transaction
busgrant  output  NUM_REQ  one-hot grant, registered
grant_id  output  ID_W  encoded index of the current owner; valid when bus_owned=1
bus_owned  output  1  a grant is currently asserted
grant_timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While reset=0 at a clk edge:
  - busgrant=0, grant_id=0, bus_owned=0, grant_timeout=0
  - FSM=ARB; round-robin pointer=0
- FSM state ARB, no owner:
  - If any busreq is set, select a winner and go to GRANTED.
  - The winner's busgrant bit, grant_id and bus_owned are registered and become visible the cycle after the request is sampled (1-cycle latency).
- Winner selection:
  - Candidate set = busreq & busurgent if that is non-zero, else busreq.
  - Winner = first candidate found scanning upward from the pointer, wrapping NUM_REQ-1 -> 0.
- FSM state GRANTED, owner holds the grant but has not started:
  - Owner busidle=0 -> go to BUSY.
  - Owner busreq=0 while busidle=1 -> withdraw grant, go to ARB. The pointer does not advance.
- FSM state BUSY, owner transaction in flight:
  - Grant is held regardless of other requests, including urgent ones.
  - Owner busidle returns to 1 -> drop busgrant next cycle, set pointer=(owner+1) mod NUM_REQ, go to ARB.
- Turnaround: there is always one dead cycle (busgrant=0) between owners. No back-to-back grants, even when the same requester is still requesting.
- Invariants:
  - busgrant is always zero or one-hot.
  - grant_id is stable for the whole ownership.
- Requester changes during ownership: busreq/busurgent changes by non-owners have no effect until ARB.
- Reset asserted mid-BUSY: the grant is dropped on that edge. The requester's own reset aborts its transaction.
- NUM_REQ=2 must reproduce the legacy two-requester behaviour with busurgent=0.

Optional Feature:
- Macro: BUS_ARBITER_WATCHDOG_EN
- Defined:
  - A counter of width $clog2(GRANT_TIMEOUT+1) clears on entry to GRANTED and increments each GRANTED cycle.
  - Reaching GRANT_TIMEOUT with the owner still busidle=1: revoke the grant, pulse grant_timeout for 1 cycle, advance the pointer past the owner, go to ARB.
  - BUSY is never timed out.
- Undefined: no counter is built; grant_timeout is tied 0; GRANTED waits indefinitely.

Test Plan:
- Single requester: NUM_REQ=4, busreq=4'b0100 at cycle 0 -> busgrant=4'b0100, grant_id=2 at cycle 1. Drive busidle[2]=0 for 3 cycles then 1 -> busgrant=0 exactly one cycle after busidle returns high.
- Round-robin: all busreq=4'b1111 held, each owner does a 2-cycle transaction -> grant order 0,1,2,3,0 with one dead cycle between grants.
- Urgent override: pointer=1, busreq=4'b1011, busurgent=4'b1000 -> grant to 3; with busurgent=0 instead -> grant to 1.
- Withdraw: granted requester 1 drops busreq while busidle=1 -> grant cleared next cycle; next arbitration with busreq=4'b0011 grants 1 again (pointer not advanced).
- Reset mid-BUSY: reset=0 during owner 2 transaction -> next edge busgrant=0, bus_owned=0; after release with busreq=4'b1111 -> grant 0.
- Watchdog (BUS_ARBITER_WATCHDOG_EN, GRANT_TIMEOUT=16): grant to 0, busidle[0] held 1 -> grant revoked and grant_timeout pulses after 16 GRANTED cycles; next grant goes to 1. Without the macro: grant persists and grant_timeout stays 0.
